// File: rtl/fft_out_streamer.sv
// Buffers one FFT result frame and streams it out over AXI-Stream, one word per handshake.
// Define FFT_OUT_BITREV_EN to read the buffer in bit-reversed index order.
module fft_out_streamer #(
    parameter int MAX_NUM_OF_SIGNALS = 8,
    parameter int SIZE_OF_SIGNAL     = 50
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    res_we_i,
    input  logic [$clog2(MAX_NUM_OF_SIGNALS)-1:0]   res_addr_i,
    input  logic [SIZE_OF_SIGNAL-1:0]               res_data_i,
    input  logic                                    res_done_i,
    output logic                                    busy_o,
    output logic                                    ms_tvalid,
    input  logic                                    ms_tready,
    output logic                                    ms_tlast,
    output logic signed [SIZE_OF_SIGNAL-1:0]        signal_o,
    output logic                                    frame_done_o
);

    localparam int N  = MAX_NUM_OF_SIGNALS;
    localparam int W  = SIZE_OF_SIGNAL;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q;
    logic [AW-1:0]         idx_q;
    logic [AW-1:0]         idx_d;
    logic [AW-1:0]         rd_addr;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  done_q;
    logic signed [W-1:0]   buf_q [N];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    always_comb begin
        idx_d = idx_q + 1'b1;
    end

`ifdef FFT_OUT_BITREV_EN
    assign rd_addr = bitrev(idx_q);
`else
    assign rd_addr = idx_q;
`endif

    // Buffer is writable only in IDLE, so it stays frozen for the whole frame.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && res_we_i) begin
            buf_q[res_addr_i] <= signed'(res_data_i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (res_done_i) begin
                        state_q  <= SEND;
                        idx_q    <= '0;
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (tvalid_q && ms_tready) begin
                        if (tlast_q) begin
                            state_q  <= IDLE;
                            idx_q    <= '0;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            tlast_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output data is gated by valid so reset forces it to zero without clearing the buffer.
    assign signal_o     = tvalid_q ? buf_q[rd_addr] : '0;
    assign ms_tvalid    = tvalid_q;
    assign ms_tlast     = tlast_q;
    assign busy_o       = (state_q == SEND);
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_fft_out_streamer.sv
// Scoreboard bench for fft_out_streamer: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_fft_out_streamer;

    localparam int N  = 8;
    localparam int W  = 50;
    localparam int AW = 3;

    logic                  clk_i = 1'b0;
    logic                  reset_i = 1'b1;
    logic                  res_we_i = 1'b0;
    logic [AW-1:0]         res_addr_i = '0;
    logic [W-1:0]          res_data_i = '0;
    logic                  res_done_i = 1'b0;
    logic                  busy_o;
    logic                  ms_tvalid;
    logic                  ms_tready = 1'b0;
    logic                  ms_tlast;
    logic signed [W-1:0]   signal_o;
    logic                  frame_done_o;

    fft_out_streamer #(
        .MAX_NUM_OF_SIGNALS (N),
        .SIZE_OF_SIGNAL     (W)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .res_we_i     (res_we_i),
        .res_addr_i   (res_addr_i),
        .res_data_i   (res_data_i),
        .res_done_i   (res_done_i),
        .busy_o       (busy_o),
        .ms_tvalid    (ms_tvalid),
        .ms_tready    (ms_tready),
        .ms_tlast     (ms_tlast),
        .signal_o     (signal_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           order[N];
    logic [W-1:0] mdl[N];
    logic         exp_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.d = mdl[order[k]];
            e.l = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!frame_done_o && n < max) begin
            tick();
            n++;
        end
        if (!frame_done_o) begin
            checks++;
            failures++;
            $display("FAIL wait_done timeout actual=%0d cycles required=frame_done_o", n);
        end
    endtask

    // Monitor: every presented word is compared with the scoreboard head.
    always @(negedge clk_i) begin
        if (reset_i) begin
            exp_done = 1'b0;
        end else begin
            if (frame_done_o || exp_done) begin
                chk("frame_done", {63'd0, frame_done_o}, {63'd0, exp_done});
            end
            exp_done = 1'b0;
            if (ms_tvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=no_word", $unsigned(signal_o));
                end else begin
                    chk(ms_tready ? "word" : "stall_word", 64'($unsigned(signal_o)), 64'(exp_q[0].d));
                    chk(ms_tready ? "tlast" : "stall_tlast", {63'd0, ms_tlast}, {63'd0, exp_q[0].l});
                    if (ms_tready) begin
                        exp_done = exp_q[0].l;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs;
        int cyc;
        bit started;
`ifdef FFT_OUT_BITREV_EN
        order = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

        // Reset state
        reset_i = 1'b1;
        repeat (2) tick();
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_tvalid", {63'd0, ms_tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, ms_tlast}, 64'd0);
        chk("rst_signal", 64'($unsigned(signal_o)), 64'd0);
        chk("rst_frame_done", {63'd0, frame_done_o}, 64'd0);
        reset_i = 1'b0;
        tick();

        // Fill buffer with buffer[a] = a
        for (int a = 0; a < N; a++) begin
            res_we_i   = 1'b1;
            res_addr_i = AW'(a);
            res_data_i = W'(a);
            mdl[a]     = W'(a);
            tick();
        end
        res_we_i = 1'b0;

        // Full-rate frame
        ms_tready = 1'b1;
        push_frame();
        res_done_i = 1'b1;
        tick();
        res_done_i = 1'b0;
        chk("latency_tvalid", {63'd0, ms_tvalid}, 64'd1);
        chk("latency_busy", {63'd0, busy_o}, 64'd1);
        wait_done(20, n);
        chk("frame_cycles", 64'(n), 64'd8);
        tick();
        chk("idle_busy", {63'd0, busy_o}, 64'd0);

        // Backpressure for 3 cycles at k=2
        push_frame();
        res_done_i = 1'b1;
        tick();
        res_done_i = 1'b0;
        tick();
        tick();
        ms_tready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_valid", {63'd0, ms_tvalid}, 64'd1);
            chk("stall_data", 64'($unsigned(signal_o)), 64'(mdl[order[2]]));
        end
        ms_tready = 1'b1;
        wait_done(20, n);
        tick();

        // Write and res_done during SEND are ignored
        ms_tready = 1'b0;
        push_frame();
        res_done_i = 1'b1;
        tick();
        res_done_i = 1'b0;
        res_we_i   = 1'b1;
        res_addr_i = '0;
        res_data_i = W'(64'h3FF);
        res_done_i = 1'b1;
        tick();
        res_we_i   = 1'b0;
        res_done_i = 1'b0;
        tick();
        ms_tready = 1'b1;
        wait_done(20, n);
        repeat (3) tick();
        chk("no_queued_frame", {63'd0, busy_o}, 64'd0);
        push_frame();
        res_done_i = 1'b1;
        tick();
        res_done_i = 1'b0;
        chk("word0_unchanged", 64'($unsigned(signal_o)), 64'd0);
        wait_done(20, n);
        tick();

        // Reset at k=5, then a fresh frame from k=0
        push_frame();
        res_done_i = 1'b1;
        tick();
        res_done_i = 1'b0;
        repeat (5) tick();
        chk("pre_reset_k5", 64'($unsigned(signal_o)), 64'(mdl[order[5]]));
        reset_i = 1'b1;
        #1;
        chk("midrst_tvalid", {63'd0, ms_tvalid}, 64'd0);
        chk("midrst_tlast", {63'd0, ms_tlast}, 64'd0);
        chk("midrst_busy", {63'd0, busy_o}, 64'd0);
        chk("midrst_signal", 64'($unsigned(signal_o)), 64'd0);
        exp_q.delete();
        tick();
        reset_i = 1'b0;
        tick();
        push_frame();
        res_done_i = 1'b1;
        tick();
        res_done_i = 1'b0;
        wait_done(20, n);
        tick();

        // Back-to-back frames: 16 handshakes in 17 cycles
        push_frame();
        res_done_i = 1'b1;
        hs = 0;
        cyc = 0;
        started = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_done_o && hs == 8) begin
                push_frame();
                res_done_i = 1'b1;
            end else begin
                res_done_i = 1'b0;
            end
            if (started || ms_tvalid) begin
                started = 1'b1;
                cyc++;
            end
            if (ms_tvalid && ms_tready) hs++;
            if (hs == 16) break;
        end
        res_done_i = 1'b0;
        chk("b2b_handshakes", 64'(hs), 64'd16);
        chk("b2b_cycles", 64'(cyc), 64'd17);
        wait_done(5, n);
        tick();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
